// File: rtl/shrink_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shrink_pkg
// Description : Shared types, constants and helpers for the shrink_box
//               NxN box-filter downscaler.
//               SHIFT_*  : latched log2(N) encodings
//               SUM_W    : width of one channel of a multi-row block sum
//               ACC_W    : width of one channel of a horizontal group sum
// Revision    : 1.0  initial release
// ============================================================================
package shrink_pkg;

  localparam logic [1:0] SHIFT_1 = 2'd0;
  localparam logic [1:0] SHIFT_2 = 2'd1;
  localparam logic [1:0] SHIFT_4 = 2'd2;

  localparam int SUM_W = 12;
  localparam int ACC_W = 10;

  typedef struct packed {
    logic [SUM_W-1:0] r;
    logic [SUM_W-1:0] g;
    logic [SUM_W-1:0] b;
  } rgb_sum;

  typedef struct packed {
    logic [ACC_W-1:0] r;
    logic [ACC_W-1:0] g;
    logic [ACC_W-1:0] b;
  } rgb_acc;

  // Encoding 3 has no 8x8 mode behind it; fold it onto the 4x4 mode.
  function automatic logic [1:0] eff_shift(input logic [1:0] s);
    return (s == 2'd3) ? SHIFT_4 : s;
  endfunction

  // Index of the last pixel/row in a group: N-1.
  function automatic logic [1:0] last_index(input logic [1:0] s);
    case (s)
      SHIFT_1: return 2'd0;
      SHIFT_2: return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  // Round-to-nearest divide by N*N. Block sums never exceed 255*N*N, so the
  // rounded quotient always fits in 8 bits.
  function automatic logic [7:0] round_avg(input logic [SUM_W-1:0] t,
                                           input logic [1:0]       s);
    if (s == SHIFT_4) return 8'((t + SUM_W'(8)) >> 4);
    return 8'((t + SUM_W'(2)) >> 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/shrink_box_if.sv
`default_nettype none
// ============================================================================
// Module      : shrink_box_if
// Description : Pixel stream bundle for shrink_box.
//               Input side : iSHIFT, iSOF, iVALID, iEOL, iR/iG/iB
//               Output side: oVALID, oEOL, oR/oG/oB
//               master = stream source / sink, slave = downscaler
// Revision    : 1.0  initial release
// ============================================================================
interface shrink_box_if;
  logic [1:0] iSHIFT;
  logic       iSOF;
  logic       iVALID;
  logic       iEOL;
  logic [7:0] iR;
  logic [7:0] iG;
  logic [7:0] iB;
  logic       oVALID;
  logic       oEOL;
  logic [7:0] oR;
  logic [7:0] oG;
  logic [7:0] oB;

  modport master (
    output iSHIFT, iSOF, iVALID, iEOL, iR, iG, iB,
    input  oVALID, oEOL, oR, oG, oB
  );

  modport slave (
    input  iSHIFT, iSOF, iVALID, iEOL, iR, iG, iB,
    output oVALID, oEOL, oR, oG, oB
  );
endinterface
`default_nettype wire

// File: rtl/shrink_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : shrink_line_buffer
// Description : Simple dual-port RAM, one write port and one synchronous
//               read port. Read data is registered and holds until the next
//               read enable.
//               clk_i   : clock
//               we_i    : write enable, waddr_i / wdata_i
//               re_i    : read enable, raddr_i
//               rdata_o : registered read data
// Revision    : 1.0  initial release
// ============================================================================
module shrink_line_buffer #(
  parameter int DEPTH  = 800,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 36
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // No reset: contents are always rewritten before they are read.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule
`default_nettype wire

// File: rtl/shrink_box.sv
`default_nettype none
// ============================================================================
// Module      : shrink_box
// Description : Integer box-filter downscaler. Averages each NxN block
//               (N = 1, 2, 4) of a raster RGB888 stream into one pixel.
//               iCLK : pixel clock
//               iRST : asynchronous active-high reset
//               bus  : shrink_box_if.slave pixel in / pixel out stream
// Revision    : 1.0  initial release
// ============================================================================
module shrink_box
  import shrink_pkg::*;
#(
  parameter int LINE_W = 800,
  parameter int ADDR_W = 10
) (
  input  logic        iCLK,
  input  logic        iRST,
  shrink_box_if.slave bus
);

  logic [1:0]        shift_q, shift_d;
  logic              armed_q, armed_d;
  logic [1:0]        hcnt_q, hcnt_d;
  logic [1:0]        vcnt_q, vcnt_d;
  logic [ADDR_W-1:0] col_q, col_d;
  rgb_acc            acc_q, acc_d;
  logic              ovalid_q, ovalid_d;
  logic              oeol_q, oeol_d;
  logic [7:0]        or_q, or_d, og_q, og_d, ob_q, ob_d;

  logic              pix_v, done;
  logic [1:0]        cur_shift, cur_h, cur_v, last_idx;
  logic [ADDR_W-1:0] cur_col;
  rgb_acc            acc_base, hsum;
  rgb_sum            total, buf_sum, lb_wdata;
  logic              lb_we, lb_re;
  logic [3*SUM_W-1:0] lb_rdata;

  assign buf_sum = lb_rdata;

  shrink_line_buffer #(
    .DEPTH  (LINE_W),
    .ADDR_W (ADDR_W),
    .DATA_W (3*SUM_W)
  ) u_line_buffer (
    .clk_i   (iCLK),
    .we_i    (lb_we),
    .waddr_i (cur_col),
    .wdata_i (lb_wdata),
    .re_i    (lb_re),
    .raddr_i (cur_col),
    .rdata_o (lb_rdata)
  );

  always_comb begin
    // A pixel qualified with iSOF already belongs to the new frame, so the
    // frame-start values override the registered counters for this cycle.
    pix_v     = bus.iVALID & (armed_q | bus.iSOF);
    cur_shift = bus.iSOF ? eff_shift(bus.iSHIFT) : shift_q;
    cur_h     = bus.iSOF ? 2'd0 : hcnt_q;
    cur_v     = bus.iSOF ? 2'd0 : vcnt_q;
    cur_col   = bus.iSOF ? '0   : col_q;
    last_idx  = last_index(cur_shift);

    acc_base  = (cur_h == 2'd0) ? '0 : acc_q;
    hsum.r    = acc_base.r + {2'b00, bus.iR};
    hsum.g    = acc_base.g + {2'b00, bus.iG};
    hsum.b    = acc_base.b + {2'b00, bus.iB};
    total.r   = buf_sum.r + {2'b00, hsum.r};
    total.g   = buf_sum.g + {2'b00, hsum.g};
    total.b   = buf_sum.b + {2'b00, hsum.b};

    done      = pix_v & (cur_shift != SHIFT_1) & (cur_h == last_idx);

    shift_d   = shift_q;
    armed_d   = armed_q;
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    col_d     = col_q;
    acc_d     = acc_q;
    ovalid_d  = 1'b0;
    oeol_d    = 1'b0;
    or_d      = or_q;
    og_d      = og_q;
    ob_d      = ob_q;
    lb_we     = 1'b0;
    lb_re     = 1'b0;
    lb_wdata  = '0;

    if (bus.iSOF) begin
      shift_d = cur_shift;
      armed_d = 1'b1;
      hcnt_d  = 2'd0;
      vcnt_d  = 2'd0;
      col_d   = '0;
    end

    if (pix_v) begin
      if (cur_shift == SHIFT_1) begin
        ovalid_d = 1'b1;
        oeol_d   = bus.iEOL;
        or_d     = bus.iR;
        og_d     = bus.iG;
        ob_d     = bus.iB;
      end else begin
        acc_d = hsum;
        // Fetch the column's partial sum early; it is held in the RAM
        // output register until the group completes.
        lb_re = (cur_h == 2'd0) && (cur_v != 2'd0);
        if (done) begin
          hcnt_d = 2'd0;
          col_d  = cur_col + ADDR_W'(1);
          if (cur_v == 2'd0) begin
            lb_we    = 1'b1;
            lb_wdata = '{r: {2'b00, hsum.r}, g: {2'b00, hsum.g}, b: {2'b00, hsum.b}};
          end else if (cur_v != last_idx) begin
            lb_we    = 1'b1;
            lb_wdata = total;
          end else begin
            ovalid_d = 1'b1;
            oeol_d   = bus.iEOL;
            or_d     = round_avg(total.r, cur_shift);
            og_d     = round_avg(total.g, cur_shift);
            ob_d     = round_avg(total.b, cur_shift);
          end
        end else begin
          hcnt_d = cur_h + 2'd1;
        end
        // End of line also drops any incomplete trailing group.
        if (bus.iEOL) begin
          hcnt_d = 2'd0;
          col_d  = '0;
          vcnt_d = (cur_v == last_idx) ? 2'd0 : cur_v + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      shift_q  <= SHIFT_1;
      armed_q  <= 1'b0;
      hcnt_q   <= 2'd0;
      vcnt_q   <= 2'd0;
      col_q    <= '0;
      acc_q    <= '0;
      ovalid_q <= 1'b0;
      oeol_q   <= 1'b0;
      or_q     <= 8'd0;
      og_q     <= 8'd0;
      ob_q     <= 8'd0;
    end else begin
      shift_q  <= shift_d;
      armed_q  <= armed_d;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      col_q    <= col_d;
      acc_q    <= acc_d;
      ovalid_q <= ovalid_d;
      oeol_q   <= oeol_d;
      or_q     <= or_d;
      og_q     <= og_d;
      ob_q     <= ob_d;
    end
  end

  assign bus.oVALID = ovalid_q;
  assign bus.oEOL   = oeol_q;
  assign bus.oR     = or_q;
  assign bus.oG     = og_q;
  assign bus.oB     = ob_q;

endmodule
`default_nettype wire

// File: tb/tb_shrink_box.sv
`default_nettype none
// ============================================================================
// Module      : tb_shrink_box
// Description : Self-checking bench for shrink_box. Frames are stored in
//               arrays; expected outputs come from plain block averaging of
//               those arrays, checked every clock.
// Revision    : 1.0  initial release
// ============================================================================
module tb_shrink_box;

  logic iCLK = 1'b0;
  logic iRST = 1'b1;

  shrink_box_if bus ();

  shrink_box #(
    .LINE_W (800),
    .ADDR_W (10)
  ) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus)
  );

  always #5 iCLK = ~iCLK;

  int vectors     = 0;
  int miscompares = 0;
  int n_obs       = 0;
  int base;

  logic [7:0] fr_r [0:7][0:15];
  logic [7:0] fr_g [0:7][0:15];
  logic [7:0] fr_b [0:7][0:15];

  logic [7:0] hold_r = 8'd0, hold_g = 8'd0, hold_b = 8'd0;
  logic [7:0] ex_r, ex_g, ex_b;
  logic       ex_v = 1'b0, ex_eol = 1'b0;

  logic [7:0] obs_r [$];
  logic       obs_eol [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: apply inputs, then compare outputs against the expectation
  // set up in ex_* (output registered one cycle after the input).
  task automatic step(input logic v, input logic sof, input logic eol, input logic [1:0] sh,
                      input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    bus.iVALID = v;
    bus.iSOF   = sof;
    bus.iEOL   = eol;
    bus.iSHIFT = sh;
    bus.iR     = r;
    bus.iG     = g;
    bus.iB     = b;
    @(posedge iCLK);
    #1;
    if (bus.oVALID === 1'b1) begin
      n_obs++;
      obs_r.push_back(bus.oR);
      obs_eol.push_back(bus.oEOL);
    end
    check("oVALID", {31'd0, bus.oVALID}, {31'd0, ex_v});
    check("oEOL", {31'd0, bus.oEOL}, {31'd0, ex_v & ex_eol});
    if (ex_v) begin
      hold_r = ex_r;
      hold_g = ex_g;
      hold_b = ex_b;
    end
    check("oR", {24'd0, bus.oR}, {24'd0, hold_r});
    check("oG", {24'd0, bus.oG}, {24'd0, hold_g});
    check("oB", {24'd0, bus.oB}, {24'd0, hold_b});
    ex_v   = 1'b0;
    ex_eol = 1'b0;
  endtask

  task automatic idle();
    ex_v = 1'b0;
    step(1'b0, 1'b0, 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)),
         8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic fill_random(input int lo, input int hi);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 16; x++) begin
        fr_r[y][x] = 8'($urandom_range(hi, lo));
        fr_g[y][x] = 8'($urandom_range(hi, lo));
        fr_b[y][x] = 8'($urandom_range(hi, lo));
      end
  endtask

  task automatic fill_s3();
    fill_random(0, 0);
    fr_r[0][0] = 8'd10; fr_r[0][1] = 8'd20; fr_r[0][2] = 8'd30; fr_r[0][3] = 8'd40;
    fr_r[1][0] = 8'd30; fr_r[1][1] = 8'd41; fr_r[1][2] = 8'd50; fr_r[1][3] = 8'd60;
  endtask

  // Drive a w x h frame (stopping after max_pix pixels) and predict each
  // output: an NxN block average, due the cycle after its bottom-right pixel.
  task automatic run_frame(input int w, input int h, input logic [1:0] sh, input int gap_max,
                           input int max_pix, input bit sof_alone);
    int n;
    int pix;
    n   = (sh == 2'd0) ? 1 : (sh == 2'd1) ? 2 : 4;
    pix = 0;
    if (sof_alone) begin
      ex_v = 1'b0;
      step(1'b0, 1'b1, 1'b0, sh, 8'd0, 8'd0, 8'd0);
    end
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (pix < max_pix) begin
          repeat ($urandom_range(gap_max, 0)) idle();
          ex_v   = 1'b0;
          ex_eol = (x == w - 1);
          if (n == 1) begin
            ex_v = 1'b1;
            ex_r = fr_r[y][x];
            ex_g = fr_g[y][x];
            ex_b = fr_b[y][x];
          end else if ((y % n == n - 1) && (x % n == n - 1)) begin
            int sr, sg, sb;
            sr = 0; sg = 0; sb = 0;
            for (int dy = 0; dy < n; dy++)
              for (int dx = 0; dx < n; dx++) begin
                sr += int'(fr_r[y - dy][x - dx]);
                sg += int'(fr_g[y - dy][x - dx]);
                sb += int'(fr_b[y - dy][x - dx]);
              end
            ex_v = 1'b1;
            ex_r = 8'((sr + n * n / 2) / (n * n));
            ex_g = 8'((sg + n * n / 2) / (n * n));
            ex_b = 8'((sb + n * n / 2) / (n * n));
          end
          step(1'b1, (pix == 0) && !sof_alone, (x == w - 1),
               (pix == 0) ? sh : 2'($urandom_range(3, 0)),
               fr_r[y][x], fr_g[y][x], fr_b[y][x]);
          pix++;
        end
      end
    end
  endtask

  initial begin
    bus.iVALID = 1'b0; bus.iSOF = 1'b0; bus.iEOL = 1'b0; bus.iSHIFT = 2'd0;
    bus.iR = 8'd0; bus.iG = 8'd0; bus.iB = 8'd0;

    // Reset state
    repeat (3) step(1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0);
    iRST = 1'b0;
    repeat (2) idle();

    // N=1 single pixel with EOL
    fr_r[0][0] = 8'd10; fr_g[0][0] = 8'd20; fr_b[0][0] = 8'd30;
    run_frame(1, 1, 2'd0, 0, 100, 1'b0);
    repeat (2) idle();

    // N=2 directed 4x2 frame
    fill_s3();
    base = n_obs;
    run_frame(4, 2, 2'd1, 0, 100, 1'b0);
    check("s3_count", 32'(n_obs - base), 32'd2);
    check("s3_first_r", {24'd0, obs_r[base]}, 32'd25);
    check("s3_first_eol", {31'd0, obs_eol[base]}, 32'd0);
    check("s3_second_eol", {31'd0, obs_eol[base + 1]}, 32'd1);
    repeat (2) idle();

    // N=4 8x4 all white
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 16; x++) begin
        fr_r[y][x] = 8'd255; fr_g[y][x] = 8'd255; fr_b[y][x] = 8'd255;
      end
    base = n_obs;
    run_frame(8, 4, 2'd2, 0, 100, 1'b0);
    check("s4_count", 32'(n_obs - base), 32'd2);
    repeat (2) idle();

    // Directed N=2 frame with random idle gaps
    fill_s3();
    base = n_obs;
    run_frame(4, 2, 2'd1, 3, 100, 1'b0);
    check("s5_count", 32'(n_obs - base), 32'd2);
    check("s5_first_r", {24'd0, obs_r[base]}, 32'd25);
    repeat (2) idle();

    // Async reset mid-frame, right after an output pulse
    fill_random(4, 255);
    run_frame(4, 4, 2'd1, 0, 6, 1'b0);
    iRST = 1'b1;
    #1;
    check("rst_oVALID", {31'd0, bus.oVALID}, 32'd0);
    check("rst_oR", {24'd0, bus.oR}, 32'd0);
    check("rst_oG", {24'd0, bus.oG}, 32'd0);
    check("rst_oB", {24'd0, bus.oB}, 32'd0);
    hold_r = 8'd0; hold_g = 8'd0; hold_b = 8'd0;
    repeat (2) step(1'b0, 1'b0, 1'b0, 2'd1, 8'd0, 8'd0, 8'd0);
    iRST = 1'b0;
    fill_random(0, 255);
    base = n_obs;
    run_frame(4, 2, 2'd1, 1, 100, 1'b0);
    check("post_rst_count", 32'(n_obs - base), 32'd2);
    repeat (2) idle();

    // 5-pixel lines with N=2: trailing pixel dropped, no oEOL
    fill_random(0, 255);
    base = n_obs;
    run_frame(5, 2, 2'd1, 0, 100, 1'b0);
    check("w5_count", 32'(n_obs - base), 32'd2);
    check("w5_eol0", {31'd0, obs_eol[base]}, 32'd0);
    check("w5_eol1", {31'd0, obs_eol[base + 1]}, 32'd0);

    // iSOF mid-row, then pass-through
    fill_random(0, 255);
    run_frame(4, 2, 2'd1, 0, 5, 1'b0);
    fill_random(0, 255);
    base = n_obs;
    run_frame(4, 2, 2'd0, 0, 100, 1'b0);
    check("sof_bypass_count", 32'(n_obs - base), 32'd8);

    // iSOF mid-block, then a fresh N=2 frame
    fill_random(0, 255);
    run_frame(4, 4, 2'd2, 0, 9, 1'b0);
    fill_random(0, 255);
    run_frame(4, 2, 2'd1, 1, 100, 1'b0);
    repeat (2) idle();

    // Random frames
    fill_random(0, 255);
    run_frame(8, 8, 2'd3, 1, 1000, 1'b0);
    fill_random(0, 255);
    run_frame(16, 8, 2'd1, 2, 1000, 1'b1);
    fill_random(0, 255);
    run_frame(12, 4, 2'd2, 0, 1000, 1'b1);
    fill_random(0, 255);
    run_frame(7, 3, 2'd0, 1, 1000, 1'b0);
    fill_random(200, 255);
    run_frame(16, 8, 2'd2, 1, 1000, 1'b0);
    repeat (4) idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
